// File: rtl/ram_init_pkg.sv
// rtl/ram_init_pkg.sv - shared constants and types for the RAM port initiator
// Purpose : default data/address widths, response buffer depth and the
//           response entry layout used by ram_port_initiator and ram_rsp_fifo.
// Ports   : none (package).
package ram_init_pkg;

  localparam int DEF_DW    = 8;
  localparam int DEF_AW    = 3;
  localparam int RSP_DEPTH = 3;

  typedef struct packed {
    logic              is_wr;
    logic [DEF_DW-1:0] data;
  } rsp_entry_t;

endpackage

// File: rtl/ram_rsp_fifo.sv
// rtl/ram_rsp_fifo.sv - small in-order response buffer with simultaneous push/pop
// Purpose : holds captured RAM responses until the client consumes them.
// Ports   : clk, rst_n (async active-low)
//           push, push_data[W-1:0] : write one entry at the tail
//           pop                    : drop the head entry (caller guarantees non-empty)
//           head[W-1:0]            : current head entry
//           count[CW-1:0]          : number of stored entries (0..DEPTH)
module ram_rsp_fifo
  import ram_init_pkg::*;
#(
  parameter int W     = $bits(rsp_entry_t),
  parameter int DEPTH = RSP_DEPTH,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/ram_port_initiator.sv
// rtl/ram_port_initiator.sv - request/response initiator for one dual-port RAM port
// Purpose : turns a valid/ready request stream into RAM port cycles, captures the
//           registered read data one cycle later and returns it through a
//           3-entry response buffer so back-pressure never drops data.
// Config  : RAM_INIT_WRITE_ACK_EN - when defined, writes also return a response
//           {is_wr=1, data=0} and consume a credit like reads.
// Ports   : clk, rst_n (async active-low)
//           req_valid/req_ready, req_wr, req_addr[AW-1:0], req_wdata[DW-1:0]
//           rsp_valid/rsp_ready, rsp_rdata[DW-1:0], rsp_is_wr
//           ram_addr[AW-1:0], ram_wdata[DW-1:0], ram_wr, ram_rdata[DW-1:0]
module ram_port_initiator
  import ram_init_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_wr,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_is_wr,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_wr,
  input  logic [DW-1:0] ram_rdata
);

`ifdef RAM_INIT_WRITE_ACK_EN
  localparam int EW = DW + 1;
`else
  localparam int EW = DW;
`endif
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int UW = CW + 1;

  logic          accept;
  logic          track;
  logic          inflight_q;
  logic          push;
  logic          pop;
  logic [CW-1:0] fifo_count;
  logic [EW-1:0] push_data;
  logic [EW-1:0] head;
  logic [UW-1:0] used;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;

  // Credits cover both buffered entries and the one read still inside the RAM,
  // so the buffer cannot overflow; only registered state feeds req_ready.
  assign used      = {1'b0, fifo_count} + UW'(inflight_q);
  assign req_ready = rst_n & (used < UW'(RSP_DEPTH));
  assign accept    = req_valid & req_ready;

`ifdef RAM_INIT_WRITE_ACK_EN
  logic inflight_wr_q;

  assign track     = accept;
  assign push_data = inflight_wr_q ? {1'b1, {DW{1'b0}}} : {1'b0, ram_rdata};
  assign rsp_is_wr = head[DW];
  assign rsp_rdata = head[DW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_wr_q <= 1'b0;
    end else begin
      inflight_wr_q <= accept & req_wr;
    end
  end
`else
  assign track     = accept & ~req_wr;
  assign push_data = ram_rdata;
  assign rsp_is_wr = 1'b0;
  assign rsp_rdata = head;
`endif

  // inflight marks that the RAM's registered output holds our data this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      inflight_q <= track;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  // The port is driven straight from the request on accept; otherwise it
  // holds the last driven address/data so the RAM inputs stay quiet.
  assign ram_addr  = accept ? req_addr  : addr_q;
  assign ram_wdata = accept ? req_wdata : wdata_q;
  assign ram_wr    = accept & req_wr;

  assign push      = inflight_q;
  assign rsp_valid = (fifo_count != '0);
  assign pop       = rsp_valid & rsp_ready;

  ram_rsp_fifo #(
    .W     (EW),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

endmodule
